// File: rtl/cam_pool_pkg.sv
// Shared types and parameter helpers for the camera average-pooling stage.
//   pool_state_t : capture FSM states
//   calc_*       : derive pooled geometry, accumulator width and divide shift
//   idx_w        : $clog2 clamped to at least one bit for vector widths
package cam_pool_pkg;

  typedef enum logic [0:0] {
    IDLE,
    CAPT
  } pool_state_t;

  localparam int unsigned PixW = 8;

  function automatic int unsigned calc_out_w(input int unsigned img_w, input int unsigned pool);
    return (pool == 0) ? 0 : img_w / pool;
  endfunction

  function automatic int unsigned calc_out_h(input int unsigned img_h, input int unsigned pool);
    return (pool == 0) ? 0 : img_h / pool;
  endfunction

  // Block mean of POOL*POOL pixels is a right shift by 2*log2(POOL).
  function automatic int unsigned calc_shift(input int unsigned pool);
    return 2 * $clog2(pool);
  endfunction

  // Worst case sum is POOL*POOL*255, which needs PixW + SHIFT bits.
  function automatic int unsigned calc_acc_w(input int unsigned pool);
    return PixW + calc_shift(pool);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/pool_acc_bank.sv
// Per-column-block accumulator bank for the pooling stage.
//   clk_i   : clock
//   we_i    : write the selected entry this cycle
//   load_i  : 1 = start a new block sum with pix_i, 0 = add pix_i to the entry
//   idx_i   : entry index (pooled column)
//   pix_i   : incoming pixel
//   sum_o   : combinational value that the write would store (entry + pix or pix)
module pool_acc_bank #(
  parameter int unsigned Entries = 40,
  parameter int unsigned AccW    = 12,
  parameter int unsigned IdxW    = 6
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic            load_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [7:0]      pix_i,
  output logic [AccW-1:0] sum_o
);

  // No reset: every entry is loaded before it is read within a frame.
  logic [AccW-1:0] mem_q [Entries];

  assign sum_o = load_i ? AccW'(pix_i) : mem_q[idx_i] + AccW'(pix_i);

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= sum_o;
    end
  end

endmodule

// File: rtl/cam_pool_downsampler.sv
// Streaming POOLxPOOL average pooling of an 8-bit raster pixel stream into a frame RAM.
//   clk, resetn        : clock, asynchronous active-low reset
//   enable, sof        : capture enable (sampled on sof), start-of-frame pulse
//   pix_valid/pix_data : input pixel stream, no backpressure
//   out_we/addr/data   : registered RAM write of one pooled pixel
//   busy               : capture in progress
//   frame_done         : pulse with the final write of a frame
//   err_short          : sticky, set when a frame restarts before completing
module cam_pool_downsampler
  import cam_pool_pkg::*;
#(
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120,
  parameter int unsigned POOL  = 4,
  localparam int unsigned OutW  = calc_out_w(IMG_W, POOL),
  localparam int unsigned OutH  = calc_out_h(IMG_H, POOL),
  localparam int unsigned AddrW = idx_w(OutW * OutH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             sof,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             out_we,
  output logic [AddrW-1:0] out_addr,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             frame_done,
  output logic             err_short
);

  localparam int unsigned AccW  = calc_acc_w(POOL);
  localparam int unsigned Shift = calc_shift(POOL);
  localparam int unsigned KW    = idx_w(OutW);
  localparam int unsigned CW    = idx_w(IMG_W);
  localparam int unsigned RW    = idx_w(IMG_H);

  if (!is_pow2(POOL)) begin : gen_bad_pool
    $error("POOL must be a power of two >= 1");
  end
  if ((POOL != 0) && ((IMG_W % POOL) != 0)) begin : gen_bad_w
    $error("IMG_W must be a multiple of POOL");
  end
  if ((POOL != 0) && ((IMG_H % POOL) != 0)) begin : gen_bad_h
    $error("IMG_H must be a multiple of POOL");
  end

  pool_state_t   state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          busy_q, we_q, done_q;
  logic [AddrW-1:0] addr_q;
  logic [7:0]    data_q;

  logic          start, abort, accept;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic [31:0]   col_x, row_x;
  logic          blk_first, emit, last_pix;
  logic [KW-1:0] k;
  logic [AccW-1:0] sum;

  assign start  = sof & enable;
  assign abort  = sof & ~enable;
  // A pixel coinciding with an accepted sof is pixel (0,0) of the new frame.
  assign accept = pix_valid & ~abort & (start | (state_q == CAPT));

  assign eff_col = start ? '0 : col_q;
  assign eff_row = start ? '0 : row_q;
  assign col_x   = 32'(eff_col);
  assign row_x   = 32'(eff_row);

  assign blk_first = ((col_x % POOL) == 0) && ((row_x % POOL) == 0);
  assign emit      = ((col_x % POOL) == POOL - 1) && ((row_x % POOL) == POOL - 1);
  assign last_pix  = (col_x == IMG_W - 1) && (row_x == IMG_H - 1);
  assign k         = KW'(col_x / POOL);

  pool_acc_bank #(
    .Entries (OutW),
    .AccW    (AccW),
    .IdxW    (KW)
  ) u_acc (
    .clk_i  (clk),
    .we_i   (accept),
    .load_i (blk_first),
    .idx_i  (k),
    .pix_i  (pix_data),
    .sum_o  (sum)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      err_d   = 1'b0;
    end else begin
      if (start) begin
        state_d = CAPT;
        col_d   = '0;
        row_d   = '0;
        if (state_q == CAPT) begin
          err_d = 1'b1;
        end
      end
      if (accept) begin
        if (last_pix) begin
          state_d = IDLE;
          col_d   = '0;
          row_d   = '0;
        end else if (col_x == IMG_W - 1) begin
          col_d = '0;
          row_d = eff_row + RW'(1);
        end else begin
          col_d = eff_col + CW'(1);
          row_d = eff_row;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      busy_q  <= (state_d == CAPT);
      we_q    <= accept & emit;
      done_q  <= accept & emit & last_pix;
      if (accept && emit) begin
        addr_q <= AddrW'((row_x / POOL) * OutW + col_x / POOL);
        data_q <= 8'(sum >> Shift);
      end
    end
  end

  assign out_we     = we_q;
  assign out_addr   = addr_q;
  assign out_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err_short  = err_q;

endmodule

// File: tb/tb_cam_pool_downsampler.sv
module tb_cam_pool_downsampler;

  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 8;
  localparam int unsigned POOL  = 4;
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned NOUT  = (IMG_W / POOL) * (IMG_H / POOL);

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       sof = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic       out_we;
  logic [1:0] out_addr;
  logic [7:0] out_data;
  logic       busy, frame_done, err_short;

  cam_pool_downsampler #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .POOL  (POOL)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .out_we     (out_we),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err_short  (err_short)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pix_cyc = 0;
  int fd_count = 0;
  int orphan_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  int w_addr[$], w_data[$], w_done[$], w_busy[$], w_cyc[$];
  always @(negedge clk) begin
    if (out_we === 1'b1) begin
      w_addr.push_back(int'(out_addr));
      w_data.push_back(int'(out_data));
      w_done.push_back(int'(frame_done));
      w_busy.push_back(int'(busy));
      w_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_count++;
    if (frame_done === 1'b1 && out_we !== 1'b1) orphan_done++;
  end

  logic [7:0] frame_pix [NPIX];
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: truncated mean of each POOLxPOOL block, in address order.
  task automatic push_model();
    for (int by = 0; by < int'(IMG_H / POOL); by++) begin
      for (int bx = 0; bx < int'(IMG_W / POOL); bx++) begin
        int s = 0;
        for (int r = 0; r < int'(POOL); r++)
          for (int c = 0; c < int'(POOL); c++)
            s += int'(frame_pix[(by * POOL + r) * IMG_W + bx * POOL + c]);
        exp_q.push_back(s / int'(POOL * POOL));
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < int'(NPIX); i++) frame_pix[i] = 8'($urandom_range(255));
  endtask

  task automatic fill_linear(input int base, input int dcol, input int drow);
    for (int r = 0; r < int'(IMG_H); r++)
      for (int c = 0; c < int'(IMG_W); c++)
        frame_pix[r * IMG_W + c] = 8'(base + dcol * c + drow * r);
  endtask

  // Leaves the last pixel on the bus so a following sof can be back-to-back.
  task automatic drive_frame(input int gap_pct, input bit sof_with_pix, input int npix);
    int n = 0;
    if (npix == int'(NPIX)) push_model();
    @(posedge clk); #1;
    sof = 1'b1;
    enable = 1'b1;
    if (sof_with_pix) begin
      pix_valid = 1'b1;
      pix_data = frame_pix[0];
      last_pix_cyc = cyc;
      n = 1;
    end else begin
      pix_valid = 1'b0;
    end
    while (n < npix) begin
      @(posedge clk); #1;
      sof = 1'b0;
      enable = 1'($urandom_range(1));
      if (int'($urandom_range(99)) < gap_pct) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_data = frame_pix[n];
        last_pix_cyc = cyc;
        n++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sof = 1'b0;
      pix_valid = 1'b0;
    end
  endtask

  task automatic pop_write(input string name, input int a, input int d, input bit lat);
    if (w_addr.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: write missing, got none expected addr %0d data %0d", name, a, d);
    end else begin
      int wa, wd, wdn, wb, wc;
      wa = w_addr.pop_front();
      wd = w_data.pop_front();
      wdn = w_done.pop_front();
      wb = w_busy.pop_front();
      wc = w_cyc.pop_front();
      chk({name, "_addr"}, wa, a);
      chk({name, "_data"}, wd, d);
      chk({name, "_done"}, wdn, (a == int'(NOUT) - 1) ? 1 : 0);
      if (a == int'(NOUT) - 1) chk({name, "_busy_at_done"}, wb, 0);
      if (lat) chk({name, "_latency"}, wc, last_pix_cyc + 1);
    end
  endtask

  task automatic check_frames(input int nf, input string name, input bit lat);
    for (int f = 0; f < nf; f++) begin
      for (int a = 0; a < int'(NOUT); a++) begin
        int d = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        pop_write(name, a, d, lat && (f == nf - 1) && (a == int'(NOUT) - 1));
      end
    end
    chk({name, "_extra_writes"}, w_addr.size(), 0);
  endtask

  task automatic clear_writes();
    w_addr.delete(); w_data.delete(); w_done.delete(); w_busy.delete(); w_cyc.delete();
  endtask

  typedef struct {
    int base;
    int dcol;
    int drow;
    int exp[4];
  } vec_t;

  vec_t tbl[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    tbl[0] = '{base: 100, dcol: 0,  drow: 0, exp: '{100, 100, 100, 100}};
    tbl[1] = '{base: 0,   dcol: 1,  drow: 8, exp: '{13, 17, 45, 49}};
    tbl[2] = '{base: 255, dcol: 0,  drow: 0, exp: '{255, 255, 255, 255}};
    tbl[3] = '{base: 0,   dcol: 32, drow: 0, exp: '{48, 176, 48, 176}};
    tbl[4] = '{base: 7,   dcol: 0,  drow: 1, exp: '{8, 8, 12, 12}};

    // Reset values.
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_out_we", out_we, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_short", err_short, 0);

    // Pixels without sof are ignored.
    for (int i = 0; i < int'(NPIX); i++) begin
      @(posedge clk); #1;
      enable = 1'b1;
      pix_valid = 1'b1;
      pix_data = 8'($urandom_range(255));
    end
    idle(3);
    chk("nosof_writes", w_addr.size(), 0);
    chk("nosof_busy", busy, 0);

    // Table-driven frames with hand-computed block means.
    for (int i = 0; i < 5; i++) begin
      fill_linear(tbl[i].base, tbl[i].dcol, tbl[i].drow);
      drive_frame(0, i[0], int'(NPIX));
      idle(3);
      exp_q.delete();
      for (int a = 0; a < int'(NOUT); a++) pop_write($sformatf("tbl%0d", i), a, tbl[i].exp[a], 1'b0);
      chk($sformatf("tbl%0d_extra_writes", i), w_addr.size(), 0);
      chk($sformatf("tbl%0d_err_short", i), err_short, 0);
    end

    // Random data with ~50% valid gaps against the model.
    for (int f = 0; f < 3; f++) begin
      fill_random();
      drive_frame(50, 1'($urandom_range(1)), int'(NPIX));
      idle(3);
      check_frames(1, $sformatf("rand%0d", f), 1'b1);
    end

    // Back-to-back frames: sof in the cycle right after the final pixel.
    fill_random();
    drive_frame(0, 1'b1, int'(NPIX));
    fill_random();
    drive_frame(0, 1'b0, int'(NPIX));
    idle(3);
    check_frames(2, "b2b", 1'b1);

    // Restart after 20 pixels of frame A.
    fill_random();
    drive_frame(0, 1'b0, 20);
    @(negedge clk);
    chk("restart_busy_a", busy, 1);
    chk("restart_err_before", err_short, 0);
    chk("restart_writes_a", w_addr.size(), 0);
    fill_random();
    drive_frame(0, 1'b1, int'(NPIX));
    idle(3);
    chk("restart_err_after", err_short, 1);
    check_frames(1, "restart_b", 1'b0);
    @(posedge clk); #1;
    sof = 1'b1;
    enable = 1'b0;
    pix_valid = 1'b1;
    pix_data = 8'd77;
    idle(3);
    chk("abort_err_cleared", err_short, 0);
    chk("abort_busy", busy, 0);
    chk("abort_writes", w_addr.size(), 0);

    // Reset pulsed mid-frame after 40 pixels.
    fill_random();
    drive_frame(0, 1'b0, 40);
    idle(1);
    chk("midrst_partial_writes", w_addr.size(), 2);
    clear_writes();
    fd0 = fd_count;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_out_we", out_we, 0);
    chk("midrst_out_addr", out_addr, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    idle(6);
    chk("midrst_no_writes", w_addr.size(), 0);
    chk("midrst_no_done", fd_count, fd0);
    fill_random();
    drive_frame(50, 1'b0, int'(NPIX));
    idle(3);
    check_frames(1, "post_rst", 1'b1);

    chk("orphan_frame_done", orphan_done, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
